sm_hex_scan: RTL

Multiplexed seven-segment scan driver that displays the CPU debug register value (`regData`) as hexadecimal digits on a common-anode/common-cathode LED display. It sits directly downstream of the top-level CPU wrapper, on the board clock, and turns the 32-bit register word into time-multiplexed digit-select and segment outputs. A frame-synchronous snapshot prevents tearing. Optional leading-zero blanking and an inter-digit ghosting guard are included.

---
 rtl/sm_hex_scan.sv | 132 +++++++++++++
 1 files changed

// File: rtl/sm_hex_scan.sv
// Multiplexed seven-segment hex scan driver with a frame-synchronous snapshot,
// optional leading-zero blanking and a per-slot ghosting guard.
module sm_hex_scan #(
    parameter int DIGITS         = 8,
    parameter int SCAN_DIV       = 16,
    parameter int BLANK          = 4,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clkIn,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dpMask,
    input  logic                  blankLeading,
    input  logic                  freeze,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frameStart
);

    localparam int                IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    localparam logic [SCAN_DIV-1:0] BLANK_C = SCAN_DIV'(BLANK);
    localparam logic [6:0]        SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_OFF   = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [SCAN_DIV-1:0] cnt;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] snap;
    logic                prime;
    logic                loaded;

    logic                cnt_max;
    logic                frame_wrap;
    logic                load;

    logic [3:0]          nib;
    logic [DIGITS-1:0]   lead_zero;
    logic                nz_acc;
    logic                on_phase;
    logic [DIGITS-1:0]   an_raw;
    logic [6:0]          seg_raw;
    logic                dp_raw;
    logic [DIGITS-1:0]   an_nxt;
    logic [6:0]          seg_nxt;
    logic                dp_nxt;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
    endfunction

    // prime is high exactly in the cycle after reset, giving the priming load
    assign cnt_max    = &cnt;
    assign frame_wrap = cnt_max && (idx == IDX_LAST);
    assign load       = !freeze && (prime || frame_wrap);

    always_comb begin
        nib       = 4'h0;
        nz_acc    = 1'b0;
        lead_zero = '0;
        // walk from the top nibble down so lead_zero[k] means nibbles k..top are all zero
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nz_acc       = nz_acc | (|snap[4*k +: 4]);
            lead_zero[k] = ~nz_acc;
            if (idx == IW'(k)) begin
                nib = snap[4*k +: 4];
            end
        end

        on_phase = (cnt >= BLANK_C);
        an_raw   = '0;
        seg_raw  = 7'h00;
        dp_raw   = 1'b0;
        if (on_phase) begin
            an_raw  = DIGITS'(1) << idx;
            seg_raw = (blankLeading && (idx != '0) && lead_zero[idx]) ? 7'h00 : glyph(nib);
            dp_raw  = dpMask[idx];
        end

        an_nxt  = (AN_ACTIVE_LOW != 0)  ? ~an_raw  : an_raw;
        seg_nxt = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
        dp_nxt  = (SEG_ACTIVE_LOW != 0) ? ~dp_raw  : dp_raw;
    end

    always_ff @(posedge clkIn) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            snap       <= '0;
            prime      <= 1'b1;
            loaded     <= 1'b0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            frameStart <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
            if (cnt_max) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            if (load) begin
                snap <= data;
            end
            prime      <= 1'b0;
            loaded     <= load;
            an         <= an_nxt;
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            frameStart <= loaded;
        end
    end

endmodule
